// File: rtl/rv32_hazard_pkg.sv
// Shared types and the interlock compare for the rv32 hazard controller.
// RV32_HAZARD_WDOG_EN in the top enables the bus stall watchdog.
package rv32_hazard_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

  localparam int unsigned NUM_STAGES = 5;
  localparam int unsigned NUM_STALL  = 4;
  localparam int unsigned REG_W      = 5;

  localparam int unsigned STG_F  = 0;
  localparam int unsigned STG_D  = 1;
  localparam int unsigned STG_E  = 2;
  localparam int unsigned STG_M  = 3;
  localparam int unsigned STG_WB = 4;

  typedef struct packed {
    logic [NUM_STALL-1:0]  stall;
    logic [NUM_STAGES-1:0] flush;
  } ctrl_t;

  // One decode source against up to two in-flight destinations; x0 never hazards.
  function automatic logic src_hit(input logic [REG_W-1:0] rs, input logic rs_rd,
                                   input logic [REG_W-1:0] rd_a, input logic rd_a_v,
                                   input logic [REG_W-1:0] rd_b, input logic rd_b_v);
    return rs_rd && (rs != '0) && ((rd_a_v && (rs == rd_a)) || (rd_b_v && (rs == rd_b)));
  endfunction

  function automatic logic interlock_hit(input logic [REG_W-1:0] rs1, input logic rs1_rd,
                                         input logic [REG_W-1:0] rs2, input logic rs2_rd,
                                         input logic [REG_W-1:0] rd_a, input logic rd_a_v,
                                         input logic [REG_W-1:0] rd_b, input logic rd_b_v);
    return src_hit(rs1, rs1_rd, rd_a, rd_a_v, rd_b, rd_b_v) ||
           src_hit(rs2, rs2_rd, rd_a, rd_a_v, rd_b, rd_b_v);
  endfunction

endpackage

// File: rtl/rv32_hazard_ctrl_if.sv
// Pipeline-side hazard signals and the per-stage stall/flush controls.
interface rv32_hazard_ctrl_if;
  import rv32_hazard_pkg::*;

  logic             fetch_wait_in;
  logic             mem_wait_in;
  logic [REG_W-1:0] decode_rs1_in;
  logic [REG_W-1:0] decode_rs2_in;
  logic             decode_rs1_read_in;
  logic             decode_rs2_read_in;
  logic [REG_W-1:0] execute_rd_in;
  logic             execute_rd_write_in;
  logic             execute_mem_read_in;
  logic [REG_W-1:0] mem_rd_in;
  logic             mem_rd_write_in;
  logic             branch_mispredict_in;
  logic             trap_in;

  logic fetch_stall_out;
  logic decode_stall_out;
  logic execute_stall_out;
  logic mem_stall_out;
  logic fetch_flush_out;
  logic decode_flush_out;
  logic execute_flush_out;
  logic mem_flush_out;
  logic writeback_flush_out;
  logic bus_timeout_out;
  logic draining_out;

  modport master (
    output fetch_wait_in, mem_wait_in, decode_rs1_in, decode_rs2_in,
           decode_rs1_read_in, decode_rs2_read_in, execute_rd_in,
           execute_rd_write_in, execute_mem_read_in, mem_rd_in,
           mem_rd_write_in, branch_mispredict_in, trap_in,
    input  fetch_stall_out, decode_stall_out, execute_stall_out, mem_stall_out,
           fetch_flush_out, decode_flush_out, execute_flush_out, mem_flush_out,
           writeback_flush_out, bus_timeout_out, draining_out
  );

  modport slave (
    input  fetch_wait_in, mem_wait_in, decode_rs1_in, decode_rs2_in,
           decode_rs1_read_in, decode_rs2_read_in, execute_rd_in,
           execute_rd_write_in, execute_mem_read_in, mem_rd_in,
           mem_rd_write_in, branch_mispredict_in, trap_in,
    output fetch_stall_out, decode_stall_out, execute_stall_out, mem_stall_out,
           fetch_flush_out, decode_flush_out, execute_flush_out, mem_flush_out,
           writeback_flush_out, bus_timeout_out, draining_out
  );
endinterface

// File: rtl/rv32_hazard_wdog.sv
// Consecutive-stall watchdog: pulses once every WDOG_CYCLES counted cycles.
module rv32_hazard_wdog #(
  parameter int unsigned WDOG_CYCLES = 256
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_count,
  output logic o_timeout_c
);
  localparam int unsigned CNT_W = $clog2(WDOG_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic             w_hit;

  assign w_hit       = i_count && (r_cnt == CNT_W'(WDOG_CYCLES - 1));
  assign o_timeout_c = w_hit;

  // Any non-counted cycle restarts the run; a hit wraps to zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (!i_count || w_hit) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/rv32_hazard_ctrl.sv
// Per-stage stall/flush sequencer for the 5-stage rv32 pipe with trap drain FSM.
// Define RV32_HAZARD_WDOG_EN to build the bus stall watchdog; otherwise bus_timeout_out is 0.
module rv32_hazard_ctrl
  import rv32_hazard_pkg::*;
#(
  parameter int unsigned BYPASSING   = 1,
  parameter int unsigned TRAP_DRAIN  = 2,
  parameter int unsigned WDOG_CYCLES = 256
) (
  input logic             clk,
  input logic             reset_n,
  rv32_hazard_ctrl_if.slave bus
);
  localparam int unsigned DRAIN_W = (TRAP_DRAIN > 1) ? $clog2(TRAP_DRAIN) : 1;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic [DRAIN_W-1:0] w_drain_nxt;
  ctrl_t              w_ctrl;
  logic               w_rd_a_v;
  logic               w_rd_b_v;
  logic               w_interlock;

  // With bypassing only a load in EX can't be forwarded; without it any pending write hazards.
  assign w_rd_a_v = (BYPASSING != 0) ? (bus.execute_mem_read_in && bus.execute_rd_write_in)
                                     : bus.execute_rd_write_in;
  assign w_rd_b_v = (BYPASSING == 0) && bus.mem_rd_write_in;

  assign w_interlock = interlock_hit(bus.decode_rs1_in, bus.decode_rs1_read_in,
                                     bus.decode_rs2_in, bus.decode_rs2_read_in,
                                     bus.execute_rd_in, w_rd_a_v,
                                     bus.mem_rd_in, w_rd_b_v);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= RUN;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_nxt;
    end
  end

  // Priority: reset > trap > drain > mem_wait > mispredict > interlock > fetch_wait.
  always_comb begin
    w_ctrl      = '0;
    w_state_nxt = r_state;
    w_drain_nxt = r_drain_cnt;
    if (!reset_n) begin
      w_ctrl.flush = '1;
      w_state_nxt  = RUN;
      w_drain_nxt  = '0;
    end else if (bus.trap_in) begin
      w_ctrl.flush[STG_F] = 1'b1;
      w_ctrl.flush[STG_D] = 1'b1;
      w_ctrl.flush[STG_E] = 1'b1;
      w_ctrl.flush[STG_M] = 1'b1;
      w_state_nxt         = DRAIN;
      w_drain_nxt         = DRAIN_W'(TRAP_DRAIN - 1);
    end else if (r_state == DRAIN) begin
      w_ctrl.flush[STG_D] = 1'b1;
      w_ctrl.flush[STG_E] = 1'b1;
      w_ctrl.flush[STG_M] = 1'b1;
      if (r_drain_cnt == '0) begin
        w_state_nxt = RUN;
      end else begin
        w_drain_nxt = r_drain_cnt - DRAIN_W'(1);
      end
    end else if (bus.mem_wait_in) begin
      w_ctrl.stall         = '1;
      w_ctrl.flush[STG_WB] = 1'b1;
    end else if (bus.branch_mispredict_in) begin
      w_ctrl.flush[STG_F] = 1'b1;
      w_ctrl.flush[STG_D] = 1'b1;
      w_ctrl.flush[STG_E] = 1'b1;
    end else if (w_interlock) begin
      w_ctrl.stall[STG_F] = 1'b1;
      w_ctrl.stall[STG_D] = 1'b1;
      w_ctrl.flush[STG_E] = 1'b1;
    end else if (bus.fetch_wait_in) begin
      w_ctrl.stall[STG_F] = 1'b1;
      w_ctrl.flush[STG_D] = 1'b1;
    end
  end

  assign bus.fetch_stall_out     = w_ctrl.stall[STG_F];
  assign bus.decode_stall_out    = w_ctrl.stall[STG_D];
  assign bus.execute_stall_out   = w_ctrl.stall[STG_E];
  assign bus.mem_stall_out       = w_ctrl.stall[STG_M];
  assign bus.fetch_flush_out     = w_ctrl.flush[STG_F];
  assign bus.decode_flush_out    = w_ctrl.flush[STG_D];
  assign bus.execute_flush_out   = w_ctrl.flush[STG_E];
  assign bus.mem_flush_out       = w_ctrl.flush[STG_M];
  assign bus.writeback_flush_out = w_ctrl.flush[STG_WB];
  assign bus.draining_out        = reset_n && (r_state == DRAIN);

`ifdef RV32_HAZARD_WDOG_EN
  logic w_wdog_count;

  // Only bus waits seen in RUN count; a trap restarts the run.
  assign w_wdog_count = reset_n && !bus.trap_in && (r_state == RUN) &&
                        (bus.mem_wait_in || bus.fetch_wait_in);

  rv32_hazard_wdog #(
    .WDOG_CYCLES (WDOG_CYCLES)
  ) u_wdog (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_count     (w_wdog_count),
    .o_timeout_c (bus.bus_timeout_out)
  );
`else
  assign bus.bus_timeout_out = 1'b0;
`endif

endmodule
